// File: rtl/pipe_pkg.sv
// Shared types and helpers for pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  localparam int PIPE_WIDTH = 32;
  localparam int PIPE_NCH   = 2;

  // LSB position of channel k on a packed NCH*WIDTH bus.
  function automatic int ch_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating cycle counter: counts cycles with en=1, sticks at all-ones, cleared only by rst.
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// NCH x WIDTH pipeline stage register with valid/ready, flush and stall count; 1-cycle latency, holds data under back-pressure.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry so in_ready has no combinational path from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = PIPE_WIDTH,
  parameter int               NCH     = PIPE_NCH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int DW = NCH * WIDTH;

  pipe_state_t   state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] rst_word;
  logic          in_xfer;

  for (genvar k = 0; k < NCH; k++) begin : g_rst_word
    assign rst_word[ch_lo(k, WIDTH) +: WIDTH] = RST_VAL;
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [DW-1:0] skid_q, skid_d;
  logic          flush_q;

  // Registered-only ready: a word landing while stalled goes to the skid entry.
  assign in_ready = (state_q != ST_SKID) && !flush_q;
`else
  assign in_ready = !flush && ((state_q == ST_EMPTY) || out_ready);
`endif

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = rst_word;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (in_xfer) main_d = in_data;
            else         state_d = ST_EMPTY;
          end
`ifdef PIPE_STAGE_REG_SKID_EN
          else if (in_xfer) begin
            state_d = ST_SKID;
            skid_d  = in_data;
          end
`endif
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        ST_SKID: begin
          if (out_ready) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= rst_word;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q  <= rst_word;
      flush_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q  <= skid_d;
      flush_q <= flush;
`endif
    end
  end

  pipe_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue-based model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W    = 32;
  localparam int N    = 2;
  localparam int DW   = W * N;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam int W2   = 8;
  localparam int N2   = 3;
  localparam int DW2  = W2 * N2;
  localparam int CW2  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  logic           b_rst, b_in_valid, b_flush, b_out_ready;
  logic [DW2-1:0] b_in_data;
  logic           b_in_ready, b_out_valid;
  logic [DW2-1:0] b_out_data;
  logic [CW2-1:0] b_stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [DW+CW:0] got, exp;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(W2), .NCH(N2), .CNT_W(CW2)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt)
  );

  assert property (@(posedge clk) disable iff (rst)
                   (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)))
    else begin
      errors++;
      $display("FAIL in_data_stable: upstream changed a stalled word");
    end

  // Reference model: words held by the stage in arrival order.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data = '0;
  int            m_cnt = 0;
  bit            m_flush_q = 1'b0;

  function automatic bit m_valid();
    return mq.size() != 0;
  endfunction

  function automatic bit m_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
    return (mq.size() < 2) && !m_flush_q;
`else
    return !flush && ((mq.size() == 0) || out_ready);
`endif
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit f, input bit o);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = o;
    #1;
  endtask

  task automatic step();
    bit ov, ir;
    ov = m_valid();
    ir = m_ready();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_data    = '0;
      m_cnt     = 0;
      m_flush_q = 1'b0;
    end else begin
      if (ov && !out_ready && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        mq.delete();
        m_data = '0;
      end else begin
        if (ov && out_ready) void'(mq.pop_front());
        if (in_valid && ir) mq.push_back(in_data);
        if (mq.size() != 0) m_data = mq[0];
      end
      m_flush_q = flush;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 64'hDEADBEEF_00000005, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      got = {out_valid, out_data, stall_cnt};
      exp = {1'b0, 64'h0, 16'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
    end
    rst = 1'b0;
    #1;
    step();
    got = {out_valid, out_data, stall_cnt};
    exp = {1'b1, 64'hDEADBEEF_00000005, 16'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_first_word got=%h exp=%h", got, exp); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready got=%b exp=1", in_ready); end
      step();
      got = {out_valid, out_data, stall_cnt};
      exp = {1'b1, DW'(i), 16'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stream_word got=%h exp=%h", got, exp); end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    got = {out_valid, out_data, stall_cnt};
    exp = {1'b0, 64'd8, 16'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL stream_drain got=%h exp=%h", got, exp); end
  endtask

  task automatic test_backpressure();
    bit v, er;
    drive(1'b1, 64'hA5, 1'b0, 1'b1);
    step();
    got = {out_valid, out_data, stall_cnt};
    exp = {1'b1, 64'hA5, 16'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_load got=%h exp=%h", got, exp); end
    for (int k = 0; k < 5; k++) begin
`ifdef PIPE_STAGE_REG_SKID_EN
      v = (k == 0); er = (k == 0);
`else
      v = 1'b1; er = 1'b0;
`endif
      drive(v, 64'hA6, 1'b0, 1'b0);
      checks++;
      if (in_ready !== er) begin errors++; $display("FAIL bp_ready got=%b exp=%b", in_ready, er); end
      step();
      got = {out_valid, out_data, stall_cnt};
      exp = {1'b1, 64'hA5, CW'(k + 1)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bp_hold got=%h exp=%h", got, exp); end
    end
`ifdef PIPE_STAGE_REG_SKID_EN
    drive(1'b0, 64'hA6, 1'b0, 1'b1);
`else
    drive(1'b1, 64'hA6, 1'b0, 1'b1);
`endif
    step();
    got = {out_valid, out_data, stall_cnt};
    exp = {1'b1, 64'hA6, 16'd5};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_release got=%h exp=%h", got, exp); end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    got = {out_valid, out_data, stall_cnt};
    exp = {1'b0, 64'hA6, 16'd5};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_drain got=%h exp=%h", got, exp); end
  endtask

  task automatic test_flush();
    bit er;
    drive(1'b1, 64'h77, 1'b0, 1'b1);
    step();
`ifdef PIPE_STAGE_REG_SKID_EN
    drive(1'b1, 64'h78, 1'b0, 1'b0);
`else
    drive(1'b0, 64'h78, 1'b0, 1'b0);
`endif
    step();
    got = {out_valid, out_data, stall_cnt};
    exp = {1'b1, 64'h77, 16'd6};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL flush_pre got=%h exp=%h", got, exp); end
    drive(1'b1, 64'h79, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    step();
    got = {out_valid, out_data, stall_cnt};
    exp = {1'b0, 64'h0, 16'd6};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL flush_bubble got=%h exp=%h", got, exp); end
    drive(1'b1, 64'h79, 1'b0, 1'b1);
`ifdef PIPE_STAGE_REG_SKID_EN
    er = 1'b0;
`else
    er = 1'b1;
`endif
    checks++;
    if (in_ready !== er) begin errors++; $display("FAIL flush_after_ready got=%b exp=%b", in_ready, er); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(1'b0, '0, 1'b0, 1'b1);
      step();
      got = {out_valid, out_data, stall_cnt};
      exp = {m_valid(), m_data, CW'(m_cnt)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL flush_recover got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit v, acc, r, f, o;
    v = 1'b0; acc = 1'b0; d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!v || acc) begin
        v = ($urandom_range(3) != 0);
        d = {$urandom, $urandom};
      end
      r = ($urandom_range(99) == 0);
      f = ($urandom_range(15) == 0);
      o = ($urandom_range(2) != 0);
      rst = r;
      drive(v, d, f, o);
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, in_ready, m_ready());
      end
      acc = v && m_ready() && !r;
      step();
      got = {out_valid, out_data, stall_cnt};
      exp = {m_valid(), m_data, CW'(m_cnt)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", i, got, exp); end
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_param_sweep();
    logic [DW2+CW2:0] g, e;
    logic [W2-1:0]    eb;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0; b_in_valid = 1'b1; b_in_data = 24'h112233;
    @(posedge clk); #1;
    for (int k = 0; k < N2; k++) begin
      eb = (k == 0) ? 8'h33 : (k == 1) ? 8'h22 : 8'h11;
      checks++;
      if (b_out_data[ch_lo(k, W2) +: W2] !== eb) begin
        errors++; $display("FAIL sweep_ch%0d got=%h exp=%h", k, b_out_data[ch_lo(k, W2) +: W2], eb);
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      g = {b_out_valid, b_out_data, b_stall_cnt};
      e = {1'b1, 24'h112233, CW2'((k + 1 > 15) ? 15 : k + 1)};
      checks++;
      if (g !== e) begin errors++; $display("FAIL sat_cnt k=%0d got=%h exp=%h", k, g, e); end
    end
    b_in_valid = 1'b1; b_in_data = 24'h445566;
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(posedge clk); #1;
    g = {b_out_valid, b_out_data, b_stall_cnt};
    e = {1'b0, 24'h0, 4'd0};
    checks++;
    if (g !== e) begin errors++; $display("FAIL sweep_rst got=%h exp=%h", g, e); end
    b_rst = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(posedge clk); #1;
    g = {b_out_valid, b_out_data, b_stall_cnt};
    checks++;
    if (g !== e) begin errors++; $display("FAIL sweep_skid_clear got=%h exp=%h", g, e); end
    checks++;
    if (b_in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready got=%b exp=1", b_in_ready); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed two-word writeback-stage register.
- Carries NCH channels of WIDTH bits each between CPU pipeline stages.
- Adds a valid/ready handshake, back-pressure stall, synchronous flush (bubble insertion) and a saturating stall counter.
- Instantiated between the EX/MEM/WB boundaries of the pipeline CPU.

Parameters:
WIDTH, 32, bits per channel
NCH, 2, number of channels carried (e.g. alu_out, ld_data)
RST_VAL, 0, value loaded into every data bit on reset and on flush
CNT_W, 16, width of stall counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream stage has data
in_ready  output  1  stage can accept data this cycle
in_data  input  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
flush  input  1  discard all held data (branch mispredict/exception)
out_valid  output  1  stage holds valid data
out_ready  input  1  downstream accepts data this cycle
out_data  output  NCH*WIDTH  held data, same packing as in_data
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (sync, on rst=1 at posedge clk):
  - out_valid=0, out_data=all RST_VAL, stall_cnt=0, state EMPTY, skid entry invalid.
  - rst has priority over flush and all transfers.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at a posedge.
  - Output transfer occurs when out_valid && out_ready at a posedge.
  - Latency: 1 cycle. Data accepted at edge N appears on out_data after edge N.
- States:
  - Base build: EMPTY and FULL only.
  - Skid build adds SKID; see Optional Feature.
- Base build:
  - in_ready = !flush && (!out_valid || out_ready). This is combinational from out_ready.
  - EMPTY + input transfer -> FULL; load data.
  - FULL + output transfer + input transfer -> FULL; load new data. Full throughput: one word per cycle.
  - FULL + output transfer, no input transfer -> EMPTY; out_data holds its last value.
  - FULL + !out_ready -> FULL; data held stable, no change allowed.
- Flush:
  - Next state EMPTY, out_valid=0, out_data=RST_VAL, skid entry discarded.
  - in_ready=0 during the flush cycle, so no word is accepted.
  - A simultaneous output transfer is still counted as consumed downstream; the stage does not re-present it.
- stall_cnt:
  - Increments each cycle out_valid && !out_ready; saturates at 2^CNT_W-1.
  - Cleared only by rst; unaffected by flush.
- out_data must not change while out_valid && !out_ready.
- Assertion (verification): in_data must be stable while in_valid && !in_ready. The block does not depend on this.

Optional Feature:
- Macro: PIPE_STAGE_REG_SKID_EN.
- Defined: adds one skid entry so in_ready is a pure register output with no out_ready->in_ready combinational path.
  - in_ready = !skid_valid && !flush_q. flush_q is flush registered, so in_ready drops the cycle after flush.
  - Flush still takes effect in its own cycle.
  - FULL + input transfer + !out_ready -> SKID; the incoming word is stored in the skid register.
  - SKID + out_ready -> FULL; the skid word moves to main. in_ready=0 in SKID.
  - Ordering is preserved and no word is dropped or duplicated.
- Undefined: base combinational-ready behaviour above; no skid storage is synthesised.

Decomposition:
- Shared package pipe_pkg:
  - state encoding typedef (EMPTY, FULL, SKID)
  - default WIDTH/NCH constants
  - channel-slice helper function
- Natural sub-module: pipe_stall_counter (saturating CNT_W counter, enable input, sync reset), reusable by other stages.
- The data register stays in the top module.

Test Plan:
- Reset with in_valid=1, in_data=0xDEADBEEF_00000005 held -> out_valid=0, out_data=0, stall_cnt=0 for every rst cycle; first word appears one edge after rst deasserts.
- Streaming: out_ready=1, words 1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, one-cycle latency, in_ready constantly 1, stall_cnt=0.
- Back-pressure: load 0xA5, hold out_ready=0 for 5 cycles -> out_data stays 0xA5, stall_cnt=5; base build in_ready=0 throughout; skid build accepts exactly one more word (0xA6) then in_ready=0; releasing out_ready yields 0xA5 then 0xA6.
- Flush while FULL (and SKID in skid build) with in_valid=1 -> next cycle out_valid=0, out_data=RST_VAL, flush-cycle input not accepted, stall_cnt unchanged.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt reaches 15 and holds.
- Parameter sweep: NCH=3, WIDTH=8 with in_data=0x112233 -> channel 0=0x33, 1=0x22, 2=0x11 on out_data; rst mid-stream clears both main and skid entries.
